// File: rtl/pipe_pkg.sv
// Shared ID/EX pipeline types: control bundle, ID/EX payload and RV32 instruction field positions.
package pipe_pkg;

   localparam int unsigned PipePcW   = 9;
   localparam int unsigned PipeDataW = 32;
   localparam int unsigned RegAddrW  = 5;

   localparam int unsigned RdLo     = 7;
   localparam int unsigned Funct3Lo = 12;
   localparam int unsigned Rs1Lo    = 15;
   localparam int unsigned Rs2Lo    = 20;
   localparam int unsigned Funct7Lo = 25;

   typedef struct packed {
      logic       alusrc;
      logic       memtoreg;
      logic       regwrite;
      logic       memread;
      logic       memwrite;
      logic [2:0] aluop;
      logic       branch;
   } ctrl_t;

   localparam ctrl_t CTRL_NOP = '0;

   // Payload widths follow PipePcW/PipeDataW; id_ex_reg parameters are expected to match them.
   typedef struct packed {
      ctrl_t                 ctrl;
      logic [PipePcW-1:0]    pc;
      logic [RegAddrW-1:0]   rs1;
      logic [RegAddrW-1:0]   rs2;
      logic [RegAddrW-1:0]   rd;
      logic [2:0]            funct3;
      logic [6:0]            funct7;
      logic [PipeDataW-1:0]  rd1;
      logic [PipeDataW-1:0]  rd2;
      logic [PipeDataW-1:0]  imm;
   } id_ex_t;

endpackage

// File: rtl/hazard_detect.sv
// Combinational load-use comparator for the ID/EX boundary.
// Only built when LOAD_USE_DETECT_EN is defined.
`ifdef LOAD_USE_DETECT_EN
module hazard_detect
   import pipe_pkg::*;
(
   input  logic                ex_valid,
   input  logic                ex_memread,
   input  logic [RegAddrW-1:0] ex_rd,
   input  logic [RegAddrW-1:0] id_rs1,
   input  logic [RegAddrW-1:0] id_rs2,
   input  logic                flush,
   output logic                hazard_stall
);

   logic rd_match;

   // A load targeting x0 never produces a value, so it cannot create a dependency.
   assign rd_match = (ex_rd != '0) && ((ex_rd == id_rs1) || (ex_rd == id_rs2));

   assign hazard_stall = ex_valid & ex_memread & rd_match & ~flush;

endmodule
`endif

// File: rtl/id_ex_reg.sv
// ID/EX pipeline register with flush/load-use bubbles and external stall hold.
// Optional load-use detection is enabled by defining LOAD_USE_DETECT_EN.
module id_ex_reg
   import pipe_pkg::*;
#(
   parameter int unsigned PC_W   = PipePcW,
   parameter int unsigned DATA_W = PipeDataW
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              stall,
   input  logic [PC_W-1:0]   id_pc,
   input  logic [31:0]       id_instr,
   input  logic              id_alusrc,
   input  logic              id_memtoreg,
   input  logic              id_regwrite,
   input  logic              id_memread,
   input  logic              id_memwrite,
   input  logic              id_branch,
   input  logic [2:0]        id_aluop,
   input  logic [DATA_W-1:0] id_rd1,
   input  logic [DATA_W-1:0] id_rd2,
   input  logic [DATA_W-1:0] id_imm,
   output logic              ex_valid,
   output logic [PC_W-1:0]   ex_pc,
   output logic [4:0]        ex_rs1,
   output logic [4:0]        ex_rs2,
   output logic [4:0]        ex_rd,
   output logic [2:0]        ex_funct3,
   output logic [6:0]        ex_funct7,
   output logic              ex_alusrc,
   output logic              ex_memtoreg,
   output logic              ex_regwrite,
   output logic              ex_memread,
   output logic              ex_memwrite,
   output logic              ex_branch,
   output logic [2:0]        ex_aluop,
   output logic [DATA_W-1:0] ex_rd1,
   output logic [DATA_W-1:0] ex_rd2,
   output logic [DATA_W-1:0] ex_imm,
   output logic              hazard_stall
);

   id_ex_t stage_q;
   id_ex_t stage_d;
   logic   valid_q;

   // Opcode is decoded upstream; only the operand fields travel to EX.
   logic unused_opcode;
   assign unused_opcode = ^id_instr[6:0];

   always_comb begin
      stage_d              = '0;
      stage_d.ctrl.alusrc   = id_alusrc;
      stage_d.ctrl.memtoreg = id_memtoreg;
      stage_d.ctrl.regwrite = id_regwrite;
      stage_d.ctrl.memread  = id_memread;
      stage_d.ctrl.memwrite = id_memwrite;
      stage_d.ctrl.aluop    = id_aluop;
      stage_d.ctrl.branch   = id_branch;
      stage_d.pc            = PipePcW'(id_pc);
      stage_d.rs1           = id_instr[Rs1Lo +: RegAddrW];
      stage_d.rs2           = id_instr[Rs2Lo +: RegAddrW];
      stage_d.rd            = id_instr[RdLo +: RegAddrW];
      stage_d.funct3        = id_instr[Funct3Lo +: 3];
      stage_d.funct7        = id_instr[Funct7Lo +: 7];
      stage_d.rd1           = PipeDataW'(id_rd1);
      stage_d.rd2           = PipeDataW'(id_rd2);
      stage_d.imm           = PipeDataW'(id_imm);
   end

`ifdef LOAD_USE_DETECT_EN
   hazard_detect u_hazard_detect (
      .ex_valid     (valid_q),
      .ex_memread   (stage_q.ctrl.memread),
      .ex_rd        (stage_q.rd),
      .id_rs1       (id_instr[Rs1Lo +: RegAddrW]),
      .id_rs2       (id_instr[Rs2Lo +: RegAddrW]),
      .flush        (flush),
      .hazard_stall (hazard_stall)
   );
`else
   assign hazard_stall = 1'b0;
`endif

   // Bubbles clear only control and valid; data fields hold and are ignored while invalid.
   always_ff @(posedge clk) begin
      if (reset) begin
         stage_q <= '0;
         valid_q <= 1'b0;
      end else if (flush) begin
         stage_q.ctrl <= CTRL_NOP;
         valid_q      <= 1'b0;
      end else if (stall) begin
         stage_q <= stage_q;
         valid_q <= valid_q;
      end
`ifdef LOAD_USE_DETECT_EN
      else if (hazard_stall) begin
         stage_q.ctrl <= CTRL_NOP;
         valid_q      <= 1'b0;
      end
`endif
      else begin
         stage_q <= stage_d;
         valid_q <= 1'b1;
      end
   end

   assign ex_valid    = valid_q;
   assign ex_pc       = PC_W'(stage_q.pc);
   assign ex_rs1      = stage_q.rs1;
   assign ex_rs2      = stage_q.rs2;
   assign ex_rd       = stage_q.rd;
   assign ex_funct3   = stage_q.funct3;
   assign ex_funct7   = stage_q.funct7;
   assign ex_alusrc   = stage_q.ctrl.alusrc;
   assign ex_memtoreg = stage_q.ctrl.memtoreg;
   assign ex_regwrite = stage_q.ctrl.regwrite;
   assign ex_memread  = stage_q.ctrl.memread;
   assign ex_memwrite = stage_q.ctrl.memwrite;
   assign ex_branch   = stage_q.ctrl.branch;
   assign ex_aluop    = stage_q.ctrl.aluop;
   assign ex_rd1      = DATA_W'(stage_q.rd1);
   assign ex_rd2      = DATA_W'(stage_q.rd2);
   assign ex_imm      = DATA_W'(stage_q.imm);

endmodule

// File: tb/tb_id_ex_reg.sv
// Bench for id_ex_reg: directed scenarios plus randomized traffic against a behavioural model.
// Expectations adapt to whether LOAD_USE_DETECT_EN is defined.
module tb_id_ex_reg;

`ifdef LOAD_USE_DETECT_EN
   localparam bit HazEn = 1'b1;
`else
   localparam bit HazEn = 1'b0;
`endif

   localparam int ObsW = 140;

   // Control vector order: alusrc memtoreg regwrite memread memwrite aluop[2:0] branch
   localparam logic [8:0] C_ADDI = 9'b1_0_1_0_0_011_0;
   localparam logic [8:0] C_LW   = 9'b1_1_1_1_0_000_0;
   localparam logic [8:0] C_ADD  = 9'b0_0_1_0_0_010_0;

   localparam logic [31:0] I_ADDI_X5 = 32'h0070_0293; // addi x5,x0,7
   localparam logic [31:0] I_LW_X6   = 32'h0000_A303; // lw x6,0(x1)
   localparam logic [31:0] I_ADD_X7  = 32'h0023_03B3; // add x7,x6,x2
   localparam logic [31:0] I_LW_X0   = 32'h0000_A003; // lw x0,0(x1)
   localparam logic [31:0] I_ADD_X3  = 32'h0000_01B3; // add x3,x0,x0

   logic        clk = 1'b0;
   logic        reset, flush, stall;
   logic [8:0]  id_pc;
   logic [31:0] id_instr;
   logic [8:0]  in_ctrl;
   logic [31:0] id_rd1, id_rd2, id_imm;

   logic        ex_valid, ex_alusrc, ex_memtoreg, ex_regwrite, ex_memread, ex_memwrite;
   logic        ex_branch, hazard_stall;
   logic [8:0]  ex_pc;
   logic [4:0]  ex_rs1, ex_rs2, ex_rd;
   logic [2:0]  ex_funct3, ex_aluop;
   logic [6:0]  ex_funct7;
   logic [31:0] ex_rd1, ex_rd2, ex_imm;

   int n_checks = 0;
   int n_fail   = 0;

   // Behavioural model of what EX holds
   logic        m_valid;
   logic [8:0]  m_ctrl, m_pc;
   logic [31:0] m_instr, m_rd1, m_rd2, m_imm;

   always #5 clk = ~clk;

   id_ex_reg #(.PC_W(9), .DATA_W(32)) dut (
      .clk          (clk),
      .reset        (reset),
      .flush        (flush),
      .stall        (stall),
      .id_pc        (id_pc),
      .id_instr     (id_instr),
      .id_alusrc    (in_ctrl[8]),
      .id_memtoreg  (in_ctrl[7]),
      .id_regwrite  (in_ctrl[6]),
      .id_memread   (in_ctrl[5]),
      .id_memwrite  (in_ctrl[4]),
      .id_aluop     (in_ctrl[3:1]),
      .id_branch    (in_ctrl[0]),
      .id_rd1       (id_rd1),
      .id_rd2       (id_rd2),
      .id_imm       (id_imm),
      .ex_valid     (ex_valid),
      .ex_pc        (ex_pc),
      .ex_rs1       (ex_rs1),
      .ex_rs2       (ex_rs2),
      .ex_rd        (ex_rd),
      .ex_funct3    (ex_funct3),
      .ex_funct7    (ex_funct7),
      .ex_alusrc    (ex_alusrc),
      .ex_memtoreg  (ex_memtoreg),
      .ex_regwrite  (ex_regwrite),
      .ex_memread   (ex_memread),
      .ex_memwrite  (ex_memwrite),
      .ex_branch    (ex_branch),
      .ex_aluop     (ex_aluop),
      .ex_rd1       (ex_rd1),
      .ex_rd2       (ex_rd2),
      .ex_imm       (ex_imm),
      .hazard_stall (hazard_stall)
   );

   function automatic logic [ObsW-1:0] obs_raw();
      return {ex_valid, ex_alusrc, ex_memtoreg, ex_regwrite, ex_memread, ex_memwrite, ex_aluop,
              ex_branch, ex_pc, ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7, ex_rd1, ex_rd2, ex_imm};
   endfunction

   // Data fields are don't-care while EX is empty
   function automatic logic [ObsW-1:0] obs();
      logic [129:0] data;
      data = {ex_pc, ex_rs1, ex_rs2, ex_rd, ex_funct3, ex_funct7, ex_rd1, ex_rd2, ex_imm};
      return {ex_valid, ex_alusrc, ex_memtoreg, ex_regwrite, ex_memread, ex_memwrite, ex_aluop,
              ex_branch, (ex_valid === 1'b1) ? data : 130'd0};
   endfunction

   function automatic logic [ObsW-1:0] expect_obs();
      logic [129:0] data;
      data = {m_pc, m_instr[19:15], m_instr[24:20], m_instr[11:7], m_instr[14:12],
              m_instr[31:25], m_rd1, m_rd2, m_imm};
      return {m_valid, m_ctrl, m_valid ? data : 130'd0};
   endfunction

   function automatic logic expect_hazard();
      logic [4:0] rd;
      rd = m_instr[11:7];
      return HazEn && m_valid && m_ctrl[5] && (rd != 5'd0) && !flush &&
             ((rd == id_instr[19:15]) || (rd == id_instr[24:20]));
   endfunction

   task automatic drive(input logic [31:0] instr, input logic [8:0] c);
      id_instr = instr;
      in_ctrl  = c;
      id_pc    = 9'($urandom);
      id_rd1   = $urandom;
      id_rd2   = $urandom;
      id_imm   = $urandom;
      #1;
   endtask

   // Advance one clock edge and move the model by the priority reset > flush > stall > hazard > load
   task automatic tick();
      logic haz;
      haz = expect_hazard();
      @(posedge clk);
      if (reset) begin
         m_valid = 1'b0; m_ctrl = '0; m_pc = '0; m_instr = '0;
         m_rd1 = '0; m_rd2 = '0; m_imm = '0;
      end else if (flush || (!stall && haz)) begin
         m_valid = 1'b0; m_ctrl = '0;
      end else if (!stall) begin
         m_valid = 1'b1; m_ctrl = in_ctrl; m_pc = id_pc; m_instr = id_instr;
         m_rd1 = id_rd1; m_rd2 = id_rd2; m_imm = id_imm;
      end
      #1;
   endtask

   task automatic test_reset();
      reset = 1'b1; flush = 1'b0; stall = 1'b0;
      for (int i = 0; i < 2; i++) begin
         drive($urandom, 9'($urandom));
         tick();
         n_checks++;
         if (obs_raw() !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs cycle %0d: got %h want 0", i, obs_raw());
         end
         n_checks++;
         if (hazard_stall !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_hazard cycle %0d: got %b want 0", i, hazard_stall);
         end
      end
      reset = 1'b0;
      drive(I_ADDI_X5, C_ADDI);
      n_checks++;
      if (hazard_stall !== 1'b0) begin
         n_fail++;
         $display("FAIL post_reset_hazard: got %b want 0", hazard_stall);
      end
      tick();
      n_checks++;
      if ({ex_valid, ex_rd, ex_alusrc, ex_regwrite, ex_aluop} !== {1'b1, 5'd5, 1'b1, 1'b1, 3'b011})
      begin
         n_fail++;
         $display("FAIL addi_load: got v=%b rd=%0d alusrc=%b regwrite=%b aluop=%b want 1 5 1 1 011",
                  ex_valid, ex_rd, ex_alusrc, ex_regwrite, ex_aluop);
      end
   endtask

   task automatic test_load_use();
      drive(I_LW_X6, C_LW);
      tick();
      drive(I_ADD_X7, C_ADD);
      n_checks++;
      if (hazard_stall !== HazEn) begin
         n_fail++;
         $display("FAIL load_use_hazard: got %b want %b", hazard_stall, HazEn);
      end
      tick();
      n_checks++;
      if ({ex_valid, ex_memread} !== {!HazEn, 1'b0}) begin
         n_fail++;
         $display("FAIL load_use_bubble: got valid=%b memread=%b want %b 0",
                  ex_valid, ex_memread, !HazEn);
      end
      n_checks++;
      if (obs() !== expect_obs()) begin
         n_fail++;
         $display("FAIL load_use_model: got %h want %h", obs(), expect_obs());
      end
      n_checks++;
      if (hazard_stall !== 1'b0) begin
         n_fail++;
         $display("FAIL load_use_hazard_drop: got %b want 0", hazard_stall);
      end
      tick();
      n_checks++;
      if ({ex_valid, ex_rs1, ex_rd, ex_regwrite} !== {1'b1, 5'd6, 5'd7, 1'b1}) begin
         n_fail++;
         $display("FAIL load_use_add: got v=%b rs1=%0d rd=%0d want 1 6 7", ex_valid, ex_rs1, ex_rd);
      end
   endtask

   task automatic test_x0_load();
      drive(I_LW_X0, C_LW);
      tick();
      drive(I_ADD_X3, C_ADD);
      n_checks++;
      if (hazard_stall !== 1'b0) begin
         n_fail++;
         $display("FAIL x0_hazard: got %b want 0", hazard_stall);
      end
      tick();
      n_checks++;
      if ({ex_valid, ex_rd, ex_rs1} !== {1'b1, 5'd3, 5'd0}) begin
         n_fail++;
         $display("FAIL x0_no_bubble: got v=%b rd=%0d rs1=%0d want 1 3 0", ex_valid, ex_rd, ex_rs1);
      end
   endtask

   task automatic test_flush_priority();
      drive(I_LW_X6, C_LW);
      tick();
      flush = 1'b1;
      drive(I_ADD_X7, C_ADD);
      n_checks++;
      if (hazard_stall !== 1'b0) begin
         n_fail++;
         $display("FAIL flush_hazard: got %b want 0", hazard_stall);
      end
      tick();
      flush = 1'b0;
      n_checks++;
      if ({ex_valid, ex_regwrite, ex_memread, ex_aluop} !== 6'd0) begin
         n_fail++;
         $display("FAIL flush_bubble: got v=%b regwrite=%b memread=%b aluop=%b want 0 0 0 000",
                  ex_valid, ex_regwrite, ex_memread, ex_aluop);
      end
   endtask

   task automatic test_stall_hold();
      logic [ObsW-1:0] held;
      logic [8:0]      new_pc;
      drive(I_ADDI_X5, C_ADDI);
      tick();
      held  = obs_raw();
      stall = 1'b1;
      for (int i = 0; i < 3; i++) begin
         drive($urandom, 9'($urandom));
         tick();
         n_checks++;
         if (obs_raw() !== held) begin
            n_fail++;
            $display("FAIL stall_hold cycle %0d: got %h want %h", i, obs_raw(), held);
         end
      end
      stall = 1'b0;
      drive(I_ADD_X3, C_ADD);
      new_pc = id_pc;
      tick();
      n_checks++;
      if ({ex_valid, ex_pc, ex_rd, ex_aluop} !== {1'b1, new_pc, 5'd3, 3'b010}) begin
         n_fail++;
         $display("FAIL stall_release: got v=%b pc=%h rd=%0d aluop=%b want 1 %h 3 010",
                  ex_valid, ex_pc, ex_rd, ex_aluop, new_pc);
      end
   endtask

   task automatic test_random();
      logic [31:0] instr;
      for (int i = 0; i < 400; i++) begin
         instr        = $urandom;
         instr[11:7]  = 5'($urandom_range(0, 3));
         instr[19:15] = 5'($urandom_range(0, 3));
         instr[24:20] = 5'($urandom_range(0, 3));
         reset = ($urandom_range(0, 49) == 0);
         flush = ($urandom_range(0, 7) == 0);
         stall = ($urandom_range(0, 5) == 0);
         drive(instr, 9'($urandom));
         if ($urandom_range(0, 1) == 1) in_ctrl[5] = 1'b1;
         #1;
         n_checks++;
         if (hazard_stall !== expect_hazard()) begin
            n_fail++;
            $display("FAIL rand_hazard iter %0d: got %b want %b", i, hazard_stall, expect_hazard());
         end
         tick();
         n_checks++;
         if (obs() !== expect_obs()) begin
            n_fail++;
            $display("FAIL rand_state iter %0d: got %h want %h", i, obs(), expect_obs());
         end
      end
      reset = 1'b0; flush = 1'b0; stall = 1'b0;
   endtask

   initial begin
      m_valid = 1'b0; m_ctrl = '0; m_pc = '0; m_instr = '0;
      m_rd1 = '0; m_rd2 = '0; m_imm = '0;
      reset = 1'b1; flush = 1'b0; stall = 1'b0;
      id_pc = '0; id_instr = '0; in_ctrl = '0; id_rd1 = '0; id_rd2 = '0; id_imm = '0;
      @(negedge clk);
      test_reset();
      test_load_use();
      test_x0_load();
      test_flush_priority();
      test_stall_hold();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
